// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor controller.
// Computes {bout, diff} = a - b - bin one bit per clock, LSB first, through a single
// full-subtractor cell. Sequence: IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a subtraction (honoured only in IDLE)
//   a, b   in   minuend / subtrahend, captured with start
//   bin    in   borrow-in, captured with start
//   busy   out  high in RUN
//   done   out  one-cycle pulse in DONE; diff/bout valid
//   diff   out  (a - b - bin) mod 2^WIDTH, held until the next accepted start
//   bout   out  final borrow-out, held until the next accepted start
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fs_d;
  logic             fs_borr;

  FullSubtractor u_fs (
    .A       (a_q[0]),
    .B       (b_q[0]),
    .C       (brw_q),
    .D       (fs_d),
    .Borr_out(fs_borr)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        brw_d  = fs_borr;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        if (cnt_q == CntLast) begin
          bout_d  = fs_borr;
          state_d = StDone;
        end else begin
          // Held on the last bit so the counter never wraps inside RUN.
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs straight from the state register.
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// Single-bit full subtractor: D = A - B - C, Borr_out set when A < B + C.
module FullSubtractor (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic D,
  output logic Borr_out
);

  assign D        = A ^ B ^ C;
  assign Borr_out = (~A & B) | (~(A ^ B) & C);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed scenarios plus a random sweep
// compared against a 9-bit arithmetic reference.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int errors = 0;
  int checks = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {borrow, difference} of an unsigned 9-bit subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic z);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, z};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || done) && guard < 40) begin
      step();
      guard++;
    end
  endtask

  // Issue one operation from IDLE and return once done is seen (or the bound expires).
  // Operand and start inputs are scrambled while the operation runs.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       output int lat, output int busy_n);
    wait_idle();
    start = 1'b1;
    a     = oa;
    b     = ob;
    bin   = obin;
    step();
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      start = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      step();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [W:0] exp;
    int guard;
    rst   = 1'b1;
    start = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (diff !== '0) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++;
    if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", bout); end
    // start held across reset: blocked while rst=1, accepted on the first edge after release.
    start = 1'b1;
    a     = 8'hC3;
    b     = 8'h4D;
    bin   = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_blocks_start busy=%b exp=0", busy); end
    rst = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_at_release busy=%b exp=1", busy); end
    guard = 0;
    while (!done && guard < 40) begin
      step();
      guard++;
    end
    exp = ref_sub(8'hC3, 8'h4D, 1'b1);
    checks++;
    if ({bout, diff} !== exp) begin
      errors++;
      $display("FAIL start_at_release_result got=%b/%h exp=%b/%h", bout, diff, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_basic();
    int lat, busy_n;
    do_op(8'h5A, 8'h3C, 1'b0, lat, busy_n);
    checks++;
    if (lat !== W + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
    checks++;
    if (busy_n !== W) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_n, W); end
    checks++;
    if (diff !== 8'h1E || bout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got=%b/%h exp=0/1e", bout, diff);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
  endtask

  task automatic test_corners();
    int lat, busy_n;
    do_op(8'h00, 8'h01, 1'b0, lat, busy_n);
    checks++;
    if (diff !== 8'hFF || bout !== 1'b1) begin
      errors++;
      $display("FAIL corner_0_minus_1 got=%b/%h exp=1/ff", bout, diff);
    end
    do_op(8'hFF, 8'hFF, 1'b1, lat, busy_n);
    checks++;
    if (diff !== 8'hFF || bout !== 1'b1) begin
      errors++;
      $display("FAIL corner_ff_ff_bin got=%b/%h exp=1/ff", bout, diff);
    end
    // diff/bout must not move while idle.
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      step();
    end
    checks++;
    if (diff !== 8'hFF || bout !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold got=%b/%h exp=1/ff", bout, diff);
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0, nbusy = 0, late_busy = 0;
    logic [W-1:0] d_at_done = '0;
    logic         b_at_done = 1'b0;
    wait_idle();
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h01;
    bin   = 1'b0;
    step();
    for (int c = 1; c <= 20; c++) begin
      start = (c >= 3 && c <= 9);
      a     = 8'h00;
      b     = 8'h00;
      if (done) begin
        ndone++;
        d_at_done = diff;
        b_at_done = bout;
      end
      if (busy) begin
        nbusy++;
        if (ndone > 0) late_busy++;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++;
    if (nbusy !== W || late_busy !== 0) begin
      errors++;
      $display("FAIL ignore_busy got=%0d late=%0d exp=%0d late=0", nbusy, late_busy, W);
    end
    checks++;
    if (d_at_done !== 8'h7F || b_at_done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result got=%b/%h exp=0/7f", b_at_done, d_at_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0;
    wait_idle();
    start = 1'b1;
    a     = 8'h00;
    b     = 8'h01;
    bin   = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c < 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b diff=%h bout=%b exp 0/0/00/0",
               busy, done, diff, bout);
    end
    for (int c = 0; c < 15; c++) begin
      if (done) ndone++;
      step();
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL midrun_no_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] r1, r2;
    int t_done[$];
    logic [W-1:0] d1 = '0, d2 = '0, d_idle = '0;
    logic         b1 = 1'b0, b2 = 1'b0, done_idle = 1'b1;
    r1 = ref_sub(8'h37, 8'hA2, 1'b1);
    r2 = ref_sub(8'hE9, 8'h19, 1'b0);
    wait_idle();
    start = 1'b1;
    a     = 8'h37;
    b     = 8'hA2;
    bin   = 1'b1;
    for (int t = 0; t <= 24; t++) begin
      step();
      if (t == 0) begin
        a   = 8'hE9;
        b   = 8'h19;
        bin = 1'b0;
      end
      if (t == 10) start = 1'b0;
      if (done) begin
        t_done.push_back(t);
        if (t_done.size() == 1) begin d1 = diff; b1 = bout; end
        if (t_done.size() == 2) begin d2 = diff; b2 = bout; end
      end
      if (t_done.size() == 1 && t == t_done[0] + 1) begin
        d_idle    = diff;
        done_idle = done;
      end
    end
    checks++;
    if (t_done.size() !== 2) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d exp=2", t_done.size());
    end else begin
      checks++;
      if (t_done[1] - t_done[0] !== W + 2) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", t_done[1] - t_done[0], W + 2);
      end
    end
    checks++;
    if ({b1, d1} !== r1) begin
      errors++;
      $display("FAIL b2b_result1 got=%b/%h exp=%b/%h", b1, d1, r1[W], r1[W-1:0]);
    end
    checks++;
    if ({b2, d2} !== r2) begin
      errors++;
      $display("FAIL b2b_result2 got=%b/%h exp=%b/%h", b2, d2, r2[W], r2[W-1:0]);
    end
    checks++;
    if (d_idle !== r1[W-1:0] || done_idle !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_hold got=%h done=%b exp=%h done=0", d_idle, done_idle, r1[W-1:0]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W:0]   exp;
    int lat, busy_n;
    for (int n = 0; n < 1000; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      exp  = ref_sub(ra, rb, rbin);
      do_op(ra, rb, rbin, lat, busy_n);
      checks++;
      if ({bout, diff} !== exp || lat !== W + 1) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h bin=%b got=%b/%h lat=%0d exp=%b/%h lat=%0d",
                 n, ra, rb, rbin, bout, diff, lat, exp[W], exp[W-1:0], W + 1);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
